// File: rtl/cnn_pkg.sv
// Shared constants for the convolution layer controller:
// FSM encoding and default pass geometry.
package cnn_pkg;

  localparam int DEPTH_DEF   = 16;
  localparam int TAPS_DEF    = 3;
  localparam int MAC_LAT_DEF = 2;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_LOAD    = 3'd1;
  localparam logic [2:0] ST_COMPUTE = 3'd2;
  localparam logic [2:0] ST_DRAIN   = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;

  function automatic int n_reads(input int depth, input int taps);
    return depth - taps + 1;
  endfunction

endpackage

// File: rtl/conv_layer_ctrl_valid_delay_line.sv
// Valid shift register matching the MAC pipeline depth;
// advances every cycle, clr empties it in one edge.
module valid_delay_line #(
  parameter int MAC_LAT = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic d,
  output logic q
);

  logic [MAC_LAT-1:0] sh_q;
  logic [MAC_LAT-1:0] sh_d;

  always_comb begin
    sh_d = '0;
    if (!clr) begin
      sh_d[0] = d;
      for (int i = 1; i < MAC_LAT; i++) begin
        sh_d[i] = sh_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q <= '0;
    end else begin
      sh_q <= sh_d;
    end
  end

  assign q = sh_q[MAC_LAT-1];

endmodule

// File: rtl/conv_layer_ctrl.sv
// Layer-pass sequencer: loads DEPTH samples, issues the
// sliding-window reads, tracks results through the MAC.
module conv_layer_ctrl
  import cnn_pkg::*;
#(
  parameter int DEPTH   = DEPTH_DEF,
  parameter int TAPS    = TAPS_DEF,
  parameter int MAC_LAT = MAC_LAT_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       Start,
  input  logic       Abort,
  input  logic       InValid,
  input  logic       Pause,
  output logic       CntStart,
  output logic       WrEn,
  output logic       ReadEn,
  output logic       OutValid,
  output logic [3:0] OutIndex,
  output logic       Busy,
  output logic       Done
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] LD_LAST = CW'(DEPTH - 1);
  localparam logic [CW-1:0] RD_LAST =
    CW'(n_reads(DEPTH, TAPS) - 1);

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] ld_q, ld_d;
  logic [CW-1:0] rd_q, rd_d;
  logic [CW-1:0] idx_q, idx_d;
  logic          kill;
  logic          ov;

  assign kill = Abort && (state_q != ST_IDLE);

  always_comb begin
    state_d  = state_q;
    ld_d     = ld_q;
    rd_d     = rd_q;
    idx_d    = idx_q;
    CntStart = 1'b0;
    WrEn     = 1'b0;
    ReadEn   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // rst_n gate keeps this Mealy pulse low in reset
        if (Start && !Abort && rst_n) begin
          CntStart = 1'b1;
          state_d  = ST_LOAD;
          ld_d     = '0;
          rd_d     = '0;
        end
      end
      ST_LOAD: begin
        WrEn = InValid;
        if (InValid) begin
          ld_d = ld_q + 1'b1;
          if (ld_q == LD_LAST) state_d = ST_COMPUTE;
        end
      end
      ST_COMPUTE: begin
        ReadEn = !Pause;
        if (!Pause) begin
          rd_d = rd_q + 1'b1;
          if (rd_q == RD_LAST) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // last result leaving the line means it is empty
        if (ov && idx_q == RD_LAST) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (CntStart) begin
      idx_d = '0;
    end else if (ov) begin
      idx_d = idx_q + 1'b1;
    end
    if (kill) begin
      state_d = ST_IDLE;
      ld_d    = '0;
      rd_d    = '0;
      idx_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ld_q    <= '0;
      rd_q    <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      ld_q    <= ld_d;
      rd_q    <= rd_d;
      idx_q   <= idx_d;
    end
  end

  valid_delay_line #(
    .MAC_LAT (MAC_LAT)
  ) u_dly (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (kill),
    .d     (ReadEn),
    .q     (ov)
  );

  assign OutValid = ov;
  assign OutIndex = 4'(idx_q);
  assign Busy     = (state_q != ST_IDLE);
  assign Done     = (state_q == ST_DONE);

endmodule

// File: tb/tb_conv_layer_ctrl.sv
// Scoreboard bench for conv_layer_ctrl: expected results are
// queued at read issue and popped when due.
module tb_conv_layer_ctrl;

  localparam int DEPTH   = 16;
  localparam int TAPS    = 3;
  localparam int MAC_LAT = 2;
  localparam int NRD     = DEPTH - TAPS + 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       Start, Abort, InValid, Pause;
  logic       CntStart, WrEn, ReadEn, OutValid;
  logic [3:0] OutIndex;
  logic       Busy, Done;

  conv_layer_ctrl #(
    .DEPTH   (DEPTH),
    .TAPS    (TAPS),
    .MAC_LAT (MAC_LAT)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .Start    (Start),
    .Abort    (Abort),
    .InValid  (InValid),
    .Pause    (Pause),
    .CntStart (CntStart),
    .WrEn     (WrEn),
    .ReadEn   (ReadEn),
    .OutValid (OutValid),
    .OutIndex (OutIndex),
    .Busy     (Busy),
    .Done     (Done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int due;
    int idx;
  } ent_t;

  ent_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   m_st = 0;
  int   m_ld = 0;
  int   m_rd = 0;
  int   m_idx = 0;
  logic [9:0] obs, expv;
  int   n_wr, n_rd, n_ov, n_done;
  int   first_rd, first_ov, last_ov, max_gap, start_cyc;

  // Drive one cycle, sample outputs, advance the reference model.
  task automatic tick(input logic s, input logic a,
                      input logic iv, input logic p);
    logic       e_ov;
    logic [3:0] e_ix;
    Start   = s;
    Abort   = a;
    InValid = iv;
    Pause   = p;
    #1;
    obs  = {CntStart, WrEn, ReadEn, OutValid, OutIndex, Busy, Done};
    e_ov = (sbq.size() > 0) && (sbq[0].due == cyc);
    e_ix = e_ov ? 4'(sbq[0].idx) : 4'(m_idx);
    expv = {m_st == 0 && s && !a, m_st == 1 && iv,
            m_st == 2 && !p, e_ov, e_ix, m_st != 0, m_st == 4};
    if (WrEn) n_wr++;
    if (Done) n_done++;
    if (ReadEn) begin
      n_rd++;
      if (first_rd < 0) first_rd = cyc;
    end
    if (OutValid) begin
      n_ov++;
      if (first_ov < 0) first_ov = cyc;
      if (last_ov >= 0 && cyc - last_ov - 1 > max_gap)
        max_gap = cyc - last_ov - 1;
      last_ov = cyc;
    end
    if (e_ov) begin
      void'(sbq.pop_front());
      m_idx++;
    end
    if (m_st != 0 && a) begin
      m_st = 0; m_ld = 0; m_rd = 0; m_idx = 0;
      sbq.delete();
    end else begin
      case (m_st)
        0: if (s && !a) begin
          m_st = 1; m_ld = 0; m_rd = 0; m_idx = 0;
        end
        1: if (iv) begin
          m_ld++;
          if (m_ld == DEPTH) m_st = 2;
        end
        2: if (!p) begin
          sbq.push_back('{cyc + MAC_LAT, m_rd});
          m_rd++;
          if (m_rd == NRD) m_st = 3;
        end
        3: if (sbq.size() == 0) m_st = 4;
        default: m_st = 0;
      endcase
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic clear_stats();
    n_wr = 0; n_rd = 0; n_ov = 0; n_done = 0;
    first_rd = -1; first_ov = -1; last_ov = -1; max_gap = 0;
  endtask

  task automatic run_pass(input string nm, input bit gap,
                          input int pause_rd, input int abort_rd,
                          input bit restart);
    int pcnt = 0;
    bit aborted = 0;
    logic s, a, iv, p;
    clear_stats();
    start_cyc = cyc;
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s_start cyc=%0d got %b exp %b",
               nm, cyc - 1, obs, expv);
    end
    for (int k = 0; k < 400 && m_st != 0; k++) begin
      iv = gap ? logic'(k % 2 == 0) : 1'b1;
      p  = (pause_rd > 0) && (n_rd == pause_rd) && (pcnt < 3);
      if (p) pcnt++;
      a  = (abort_rd > 0) && !aborted && (n_rd == abort_rd);
      if (a) aborted = 1;
      s  = restart;
      tick(s, a, iv, p);
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL %s cyc=%0d got %b exp %b",
                 nm, cyc - 1, obs, expv);
      end
    end
    checks++;
    if (m_st != 0) begin
      errors++;
      $display("FAIL %s_timeout state=%0d required 0", nm, m_st);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    Start = 1'b1; Abort = 1'b0; InValid = 1'b1; Pause = 1'b0;
    #2;
    obs = {CntStart, WrEn, ReadEn, OutValid, OutIndex, Busy, Done};
    checks++;
    if (obs !== 10'b0) begin
      errors++;
      $display("FAIL reset got %b required 0", obs);
    end
    @(posedge clk);
    cyc++;
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_nominal();
    run_pass("nominal", 1'b0, 0, 0, 1'b0);
    checks++;
    if (n_wr !== DEPTH || n_rd !== NRD || n_ov !== NRD) begin
      errors++;
      $display("FAIL nominal_counts wr=%0d rd=%0d ov=%0d required %0d %0d %0d",
               n_wr, n_rd, n_ov, DEPTH, NRD, NRD);
    end
    checks++;
    if (first_ov - first_rd !== MAC_LAT) begin
      errors++;
      $display("FAIL nominal_latency got %0d required %0d",
               first_ov - first_rd, MAC_LAT);
    end
    checks++;
    if (n_done !== 1 || max_gap !== 0) begin
      errors++;
      $display("FAIL nominal_done done=%0d gap=%0d required 1 0",
               n_done, max_gap);
    end
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (Busy !== 1'b0 || obs !== expv) begin
      errors++;
      $display("FAIL nominal_idle got %b exp %b", obs, expv);
    end
  endtask

  task automatic test_gapped();
    run_pass("gapped", 1'b1, 0, 0, 1'b0);
    checks++;
    if (first_rd - start_cyc - 1 !== 2 * DEPTH - 1) begin
      errors++;
      $display("FAIL gapped_load_len got %0d required %0d",
               first_rd - start_cyc - 1, 2 * DEPTH - 1);
    end
    checks++;
    if (n_wr !== DEPTH) begin
      errors++;
      $display("FAIL gapped_wr got %0d required %0d", n_wr, DEPTH);
    end
  endtask

  task automatic test_pause();
    run_pass("pause", 1'b0, 5, 0, 1'b0);
    checks++;
    if (n_rd !== NRD || n_ov !== NRD || max_gap !== 3) begin
      errors++;
      $display("FAIL pause rd=%0d ov=%0d gap=%0d required %0d %0d 3",
               n_rd, n_ov, max_gap, NRD, NRD);
    end
  endtask

  task automatic test_abort();
    run_pass("abort", 1'b0, 0, 7, 1'b0);
    checks++;
    if (n_done !== 0) begin
      errors++;
      $display("FAIL abort_done got %0d required 0", n_done);
    end
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (Busy !== 1'b0 || OutValid !== 1'b0 || obs !== expv) begin
      errors++;
      $display("FAIL abort_idle got %b exp %b", obs, expv);
    end
    run_pass("after_abort", 1'b0, 0, 0, 1'b0);
    checks++;
    if (n_ov !== NRD || n_done !== 1) begin
      errors++;
      $display("FAIL after_abort ov=%0d done=%0d required %0d 1",
               n_ov, n_done, NRD);
    end
  endtask

  task automatic test_start_abort_idle();
    tick(1'b1, 1'b1, 1'b0, 1'b0);
    checks++;
    if (CntStart !== 1'b0 || obs !== expv) begin
      errors++;
      $display("FAIL start_abort got %b exp %b", obs, expv);
    end
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (Busy !== 1'b0 || obs !== expv) begin
      errors++;
      $display("FAIL start_abort_idle got %b exp %b", obs, expv);
    end
  endtask

  task automatic test_reset_mid_drain();
    clear_stats();
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 100 && m_st != 3; k++) begin
      tick(1'b1, 1'b0, 1'b1, 1'b0);
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL busy_start cyc=%0d got %b exp %b",
                 cyc - 1, obs, expv);
      end
    end
    checks++;
    if (m_st != 3) begin
      errors++;
      $display("FAIL drain_timeout state=%0d required 3", m_st);
    end
    Start = 1'b1;
    rst_n = 1'b0;
    #1;
    obs = {CntStart, WrEn, ReadEn, OutValid, OutIndex, Busy, Done};
    checks++;
    if (obs !== 10'b0) begin
      errors++;
      $display("FAIL reset_drain got %b required 0", obs);
    end
    m_st = 0; m_ld = 0; m_rd = 0; m_idx = 0;
    sbq.delete();
    @(posedge clk);
    cyc++;
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick(1'b0, 1'b0, 1'b1, 1'b0);
      checks++;
      if (obs !== 10'b0 || obs !== expv) begin
        errors++;
        $display("FAIL post_reset cyc=%0d got %b exp %b",
                 cyc - 1, obs, expv);
      end
    end
    run_pass("after_reset", 1'b0, 0, 0, 1'b0);
    checks++;
    if (n_ov !== NRD || n_done !== 1) begin
      errors++;
      $display("FAIL after_reset ov=%0d done=%0d required %0d 1",
               n_ov, n_done, NRD);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_gapped();
    test_pause();
    test_abort();
    test_start_abort_idle();
    run_pass("restart_ignored", 1'b0, 0, 0, 1'b1);
    test_reset_mid_drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv_layer_ctrl.md
CONV_LAYER_CTRL -- requirements
Module: conv_layer_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning register-file entries per layer pass (input samples).
REQ-002 SHALL have parameter TAPS, default 3, meaning kernel taps read per output.
REQ-003 SHALL have parameter MAC_LAT, default 2, meaning cycles from a read cycle to its MAC result.
REQ-004 SHALL have port clk, input, 1, the single clock; all flops rise on clk.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port Start, input, 1, request to begin a layer pass.
REQ-007 SHALL have port Abort, input, 1, synchronous cancel of the current pass.
REQ-008 SHALL have port InValid, input, 1, input sample present this cycle.
REQ-009 SHALL have port Pause, input, 1, suspends issue of new reads.
REQ-010 SHALL have port CntStart, output, 1, one-cycle pulse that reinitialises the address counters.
REQ-011 SHALL have port WrEn, output, 1, register-file write strobe.
REQ-012 SHALL have port ReadEn, output, 1, read/advance strobe to the address counters.
REQ-013 SHALL have port OutValid, output, 1, MAC result valid.
REQ-014 SHALL have port OutIndex, output, 4, index of the current valid result (0..DEPTH-TAPS).
REQ-015 SHALL have port Busy, output, 1, high in any state except IDLE.
REQ-016 SHALL have port Done, output, 1, one-cycle pass-complete pulse.

Function
REQ-017 SHALL implement states IDLE, LOAD, COMPUTE, DRAIN and DONE.
REQ-018 IDLE: Start=1 SHALL move to LOAD and drive CntStart=1 in that same cycle; Start is ignored in every other state.
REQ-019 LOAD: WrEn SHALL equal InValid; each cycle with InValid=1 increments the load count; when the DEPTH-th sample is written, the FSM SHALL go to COMPUTE on the next edge.
REQ-020 COMPUTE: ReadEn SHALL be Pause==0; the FSM issues exactly DEPTH-TAPS+1 read cycles (14 at defaults), then goes to DRAIN.
REQ-021 Pause=1 SHALL hold ReadEn=0 and freeze the issue count; results already in flight still complete.
REQ-022 OutValid SHALL equal ReadEn delayed by exactly MAC_LAT cycles via a shift register that advances every cycle independent of Pause.
REQ-023 OutIndex SHALL start at 0 for the pass and increment after each OutValid cycle; it wraps to 0 only on CntStart.
REQ-024 DRAIN SHALL last until the delay line is empty, then go to DONE.
REQ-025 DONE SHALL assert Done=1 for one cycle, then return to IDLE; Busy is 0 in that next IDLE cycle.
REQ-026 Abort=1 in any non-IDLE state SHALL go to IDLE on the next edge, clear counts and the delay line, and suppress Done; Abort has priority over all other transitions.
REQ-027 Start and Abort both high in IDLE SHALL leave the FSM in IDLE with no CntStart.
REQ-028 InValid outside LOAD SHALL be ignored, with WrEn=0.
REQ-029 Counters SHALL be sized with clog2(DEPTH+1) bits; no counter SHALL wrap within a pass.

Reset
REQ-030 rst_n=0 SHALL immediately force IDLE, clear all counts and the delay line, and drive every output to 0.
REQ-031 Reset asserted mid-pass SHALL discard the pass; after release, the FSM SHALL wait for a new Start.

Structure
REQ-032 The state encoding and the defaults for DEPTH, TAPS and MAC_LAT SHALL live in shared package cnn_pkg.
REQ-033 The delay line SHALL be a sub-module valid_delay_line (parameter MAC_LAT, ports clk, rst_n, clr, d, q).
REQ-034 The controller SHALL drive the existing address counter's Start and ReadEn inputs directly from CntStart and ReadEn.

Verification
REQ-035 Nominal pass: Start, 16 back-to-back InValid -> 16 WrEn, 14 ReadEn, 14 OutValid with OutIndex 0..13, first OutValid 2 cycles after first ReadEn, one Done.
REQ-036 Gapped load: InValid alternating 1/0 -> LOAD lasts 31 cycles, WrEn exactly 16, COMPUTE entered after the 16th write.
REQ-037 Pause for 3 cycles after the 5th read -> ReadEn low for those 3 cycles, 14 reads total, OutValid gap of 3, OutIndex continuous.
REQ-038 Abort in COMPUTE after 7 reads -> IDLE next cycle, OutValid stops immediately, no Done; a following Start yields a clean pass with OutIndex from 0.
REQ-039 rst_n pulsed low mid-DRAIN -> all outputs 0 asynchronously, IDLE after release; Start during Busy ignored.
